// File: rtl/tile_dispatch_ctrl_pkg.sv
// tile_dispatch_ctrl_pkg
//   Shared definitions for the tiling pipeline: route encoding, dispatcher
//   FSM state encoding and a small helper used to test engine availability.
//   The allocator and the engine wrappers import the same encodings, so a
//   route bit means the same thing everywhere.
package tile_dispatch_ctrl_pkg;

  // Route encoding carried with every decision
  localparam logic ROUTE_CNN  = 1'b1;
  localparam logic ROUTE_LITE = 1'b0;

  // Dispatcher FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } disp_state_e;

  // Busy flag of the engine selected by a route bit
  function automatic logic engine_busy(input logic route,
                                       input logic cnn_b,
                                       input logic lite_b);
    return (route == ROUTE_CNN) ? cnn_b : lite_b;
  endfunction

endpackage

// File: rtl/tile_dispatch_ctrl_dispatch_queue.sv
// dispatch_queue
//   Synchronous FIFO holding routing decisions {route, tile_id}.
//   Head entry is presented combinationally on oData (show-ahead).
//   A push while full is accepted only when a pop happens in the same cycle.
//   Ports:
//     iClk, iRst      clock, synchronous active-low reset
//     iPush, iData    write request and entry
//     iPop            consume head (ignored when empty)
//     oData           current head entry
//     oCount          number of valid entries (0..DEPTH)
//     oFull, oEmpty   occupancy flags
module dispatch_queue #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oData,
  output logic [AW:0]      oCount,
  output logic             oFull,
  output logic             oEmpty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        do_push, do_pop;

  assign oEmpty  = (count == '0);
  assign oFull   = (count == (AW+1)'(DEPTH));
  assign do_pop  = iPop && !oEmpty;
  // The slot freed by a same-cycle pop makes room for the push at full
  assign do_push = iPush && (!oFull || do_pop);

  assign oData  = mem[rd_ptr];
  assign oCount = count;

  // Storage carries no reset; only pointers and count define validity
  always_ff @(posedge iClk) begin
    if (do_push) mem[wr_ptr] <= iData;
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tile_dispatch_ctrl.sv
// tile_dispatch_ctrl
//   Sequencer between the workload allocator and the CNN / lite engines.
//   Decisions are queued in order; the head tile is dispatched to its engine
//   once that engine is free, and its TILE_PIXELS pixels are streamed out of
//   the shared pixel FIFO. Each engine holds at most one outstanding tile.
//   Ports:
//     iClk, iRst                 clock, synchronous active-low reset
//     iDecisionValid, iRouteToCnn  decision pulse and its route (1 = CNN)
//     iPixAvail                  pixel FIFO non-empty
//     iCnnDone, iLiteDone        engine completion pulses
//     oRdEn                      pixel FIFO read enable
//     oStreamValid, oStreamSel, oStreamLast  pixel stream to the engines
//     oCnnStart, oLiteStart      one-cycle engine start pulses
//     oTileId                    tile being dispatched / streamed
//     oQueueCount, oOverflow     queue occupancy, sticky drop flag
//     oIdle                      nothing queued, FSM idle, engines free
//     oCnnTiles, oLiteTiles      wrapping per-engine dispatch counters
module tile_dispatch_ctrl
  import tile_dispatch_ctrl_pkg::*;
#(
  parameter int TILE_PIXELS = 256,
  parameter int QUEUE_DEPTH = 4,
  parameter int TILE_ID_W   = 4,
  parameter int CNT_W       = 16
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iDecisionValid,
  input  logic                           iRouteToCnn,
  input  logic                           iPixAvail,
  input  logic                           iCnnDone,
  input  logic                           iLiteDone,
  output logic                           oRdEn,
  output logic                           oStreamValid,
  output logic                           oStreamSel,
  output logic                           oStreamLast,
  output logic                           oCnnStart,
  output logic                           oLiteStart,
  output logic [TILE_ID_W-1:0]           oTileId,
  output logic [$clog2(QUEUE_DEPTH):0]   oQueueCount,
  output logic                           oOverflow,
  output logic                           oIdle,
  output logic [CNT_W-1:0]               oCnnTiles,
  output logic [CNT_W-1:0]               oLiteTiles
);

  localparam int QCW = $clog2(QUEUE_DEPTH) + 1;
  localparam int BW  = (TILE_PIXELS > 1) ? $clog2(TILE_PIXELS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(TILE_PIXELS - 1);

  disp_state_e          state;
  logic                 cnn_busy, lite_busy;
  logic [TILE_ID_W-1:0] next_id;
  logic [BW-1:0]        beat;

  logic [TILE_ID_W:0]   q_head;
  logic [QCW-1:0]       q_count;
  logic                 q_full, q_empty;
  logic                 head_route;
  logic [TILE_ID_W-1:0] head_id;

  logic dispatch, accept, rd_en, last_beat;

  assign {head_route, head_id} = q_head;

  // Head-of-line: only the head is ever considered, so order is preserved
  assign dispatch = (state == ST_IDLE) && !q_empty &&
                    !engine_busy(head_route, cnn_busy, lite_busy);

  // Mirrors the queue's own acceptance rule so ID and overflow track it
  assign accept = iDecisionValid && (!q_full || dispatch);

  // Reset gates the read so an aborted tile never pulls another pixel
  assign rd_en     = iRst && (state == ST_STREAM) && iPixAvail;
  assign last_beat = rd_en && (beat == LAST_BEAT);

  assign oRdEn       = rd_en;
  assign oQueueCount = q_count;
  assign oIdle       = q_empty && (state == ST_IDLE) && !cnn_busy && !lite_busy;

  dispatch_queue #(
    .WIDTH (TILE_ID_W + 1),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .iClk   (iClk),
    .iRst   (iRst),
    .iPush  (iDecisionValid),
    .iData  ({iRouteToCnn, next_id}),
    .iPop   (dispatch),
    .oData  (q_head),
    .oCount (q_count),
    .oFull  (q_full),
    .oEmpty (q_empty)
  );

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state        <= ST_IDLE;
      cnn_busy     <= 1'b0;
      lite_busy    <= 1'b0;
      next_id      <= '0;
      beat         <= '0;
      oStreamValid <= 1'b0;
      oStreamSel   <= 1'b0;
      oStreamLast  <= 1'b0;
      oCnnStart    <= 1'b0;
      oLiteStart   <= 1'b0;
      oTileId      <= '0;
      oOverflow    <= 1'b0;
      oCnnTiles    <= '0;
      oLiteTiles   <= '0;
    end else begin
      oCnnStart  <= 1'b0;
      oLiteStart <= 1'b0;

      // FIFO read latency is one cycle
      oStreamValid <= rd_en;
      oStreamLast  <= last_beat;

      if (accept)                          next_id   <= next_id + 1'b1;
      if (iDecisionValid && !accept)       oOverflow <= 1'b1;

      // Done for an idle engine is a no-op; dispatch below never targets a
      // busy engine, so the two never fight over the same flag
      if (iCnnDone  && cnn_busy)  cnn_busy  <= 1'b0;
      if (iLiteDone && lite_busy) lite_busy <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dispatch) begin
            state      <= ST_STREAM;
            beat       <= '0;
            oTileId    <= head_id;
            oStreamSel <= head_route;
            if (head_route == ROUTE_CNN) begin
              cnn_busy  <= 1'b1;
              oCnnStart <= 1'b1;
              oCnnTiles <= oCnnTiles + 1'b1;
            end else begin
              lite_busy  <= 1'b1;
              oLiteStart <= 1'b1;
              oLiteTiles <= oLiteTiles + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          // Beat count advances only on actual reads, so stalls stretch time
          // but never change the tile length
          if (rd_en) begin
            if (last_beat) begin
              beat  <= '0;
              state <= ST_DRAIN;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Final FIFO output is presented this cycle
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
